// File: rtl/i2c_write_master_arb_pkg.sv
// i2c_pkg: shared types and constants for the I2C write master.
//   state_t    FSM states (IDLE, ARB, START, ADDR, AACK, DATA, DACK, STOP)
//   I2C_WR     R/W bit value for a write
//   I2C_ACK    SDA level a slave drives to acknowledge
//   idx_width  bits needed to index n requesters (at least 1)
package i2c_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_START = 3'd2,
        S_ADDR  = 3'd3,
        S_AACK  = 3'd4,
        S_DATA  = 3'd5,
        S_DACK  = 3'd6,
        S_STOP  = 3'd7
    } state_t;

    localparam logic I2C_WR  = 1'b0;
    localparam logic I2C_ACK = 1'b0;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/i2c_write_master_arb_if.sv
// i2c_write_master_arb_if: requester side and I2C pins of the write master.
//   req/req_addr/req_data  per-requester request level, 7-bit address, data byte
//   grant/busy/done/nack   owner one-hot, activity, end pulse, ack result
//   scl/sda_oe/sda_i       push-pull SCL, SDA pull-low enable, sampled SDA
//
// Handshake: a requester raises req[i] with req_addr/req_data stable and keeps
// them stable until grant[i] rises; the engine latches them at that moment and
// ignores later changes. grant[i] stays high until the cycle done pulses, where
// nack reports the result. A requester that still holds req after done is
// served again at the next arbitration.
interface i2c_write_master_arb_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;
    logic                 done;
    logic                 nack;
    logic                 scl;
    logic                 sda_oe;
    logic                 sda_i;

    modport master (
        input  req, req_addr, req_data, sda_i,
        output grant, busy, done, nack, scl, sda_oe
    );

    modport slave (
        output req, req_addr, req_data, sda_i,
        input  grant, busy, done, nack, scl, sda_oe
    );
endinterface

// File: rtl/i2c_write_master_arb_rr_arbiter.sv
// i2c_rr_arbiter: combinational round-robin pick.
//   req           request levels
//   last_grant    index served most recently
//   grant_onehot  first requester after last_grant (wrapping), zero if none
//   grant_idx     index of that requester (last_grant if none)
module i2c_rr_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0]   grant_idx
);
    logic [IDX_W-1:0] cand;

    // Walk candidates from farthest to nearest so the nearest one after
    // last_grant overwrites the others.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = last_grant;
        cand         = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (req[cand]) begin
                grant_onehot       = '0;
                grant_onehot[cand] = 1'b1;
                grant_idx          = cand;
            end
        end
    end
endmodule

// File: rtl/i2c_write_master_arb.sv
// i2c_write_master_arb: single-master I2C write engine shared by NUM_REQ
// requesters. Each transaction: START, {addr,W}, ACK, data byte, ACK, STOP;
// an address NACK skips the data byte.
//   clk, rst      clock, asynchronous active-high reset
//   bus           i2c_write_master_arb_if.master (requests, grant, status, pins)
//   dbg_state_o   current FSM state
module i2c_write_master_arb
    import i2c_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CLK_DIV = 250
) (
    input  logic                   clk,
    input  logic                   rst,
    i2c_write_master_arb_if.master bus,
    output state_t                 dbg_state_o
);
    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         qtr_q, qtr_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               nack_r_q, nack_r_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               scl_q, scl_d, sda_oe_q, sda_oe_d;
    logic               busy_q, busy_d, done_q, done_d, nack_q, nack_d;
    logic               tick, slot_end;
    logic [NUM_REQ-1:0] arb_onehot;
    logic [IDX_W-1:0]   arb_idx;

    i2c_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .req          (bus.req),
        .last_grant   (last_q),
        .grant_onehot (arb_onehot),
        .grant_idx    (arb_idx)
    );

    // Quarter tick; the counter is parked at 0 in IDLE/ARB so it never fires there.
    assign tick     = (cnt_q == CNT_LAST);
    assign slot_end = tick && (qtr_q == 2'd3);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            qtr_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            nack_r_q <= 1'b0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            grant_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            qtr_q    <= qtr_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            nack_r_q <= nack_r_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        qtr_d    = qtr_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        nack_r_d = nack_r_q;
        last_d   = last_q;
        grant_d  = grant_q;

        if (state_q == S_IDLE || state_q == S_ARB) begin
            cnt_d = '0;
            qtr_d = '0;
            bit_d = '0;
        end else if (tick) begin
            cnt_d = '0;
            qtr_d = qtr_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: if (|bus.req) state_d = S_ARB;
            S_ARB: begin
                if (|bus.req) begin
                    state_d  = S_START;
                    last_d   = arb_idx;
                    grant_d  = arb_onehot;
                    shift_d  = {bus.req_addr[int'(arb_idx)*7 +: 7], I2C_WR};
                    data_d   = bus.req_data[int'(arb_idx)*8 +: 8];
                    nack_r_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: if (slot_end) state_d = S_ADDR;
            S_ADDR, S_DATA: begin
                if (slot_end) begin
                    shift_d = {shift_q[6:0], 1'b0};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = (state_q == S_ADDR) ? S_AACK : S_DACK;
                end
            end
            S_AACK, S_DACK: begin
                // Sample on the edge that raises SCL (entry into q2).
                if (tick && qtr_q == 2'd1 && bus.sda_i != I2C_ACK) nack_r_d = 1'b1;
                if (slot_end) begin
                    if (state_q == S_AACK && !nack_r_q) begin
                        state_d = S_DATA;
                        shift_d = data_q;
                    end else begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (slot_end) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: pin levels are derived from the upcoming state so that
    // scl/sda_oe are plain flops aligned with the state they belong to.
    always_comb begin
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            S_START: begin
                scl_d    = (qtr_d != 2'd3);
                sda_oe_d = qtr_d[1];
            end
            S_ADDR, S_DATA: begin
                scl_d    = qtr_d[1];
                sda_oe_d = ~shift_d[7];
            end
            S_AACK, S_DACK: scl_d = qtr_d[1];
            S_STOP: begin
                scl_d    = (qtr_d != 2'd0);
                sda_oe_d = ~qtr_d[1];
            end
            default: ;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_STOP) && slot_end;
        nack_d = nack_q;
        if (state_q == S_ARB) nack_d = 1'b0;
        if (done_d) nack_d = nack_r_q;
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q    <= 1'b1;
            sda_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            scl_q    <= scl_d;
            sda_oe_q <= sda_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            nack_q   <= nack_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.nack    = nack_q;
    assign bus.scl     = scl_q;
    assign bus.sda_oe  = sda_oe_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_i2c_write_master_arb.sv
module tb_i2c_write_master_arb;
  localparam int NUM_REQ = 2;
  localparam int CLK_DIV = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  i2c_pkg::state_t dbg_state;

  always #5 clk = ~clk;

  i2c_write_master_arb_if #(.NUM_REQ(NUM_REQ)) bus ();

  i2c_write_master_arb #(.NUM_REQ(NUM_REQ), .CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  // record: {grant[1:0], addr[6:0], data[7:0], ack_addr, ack_data}
  logic [18:0] exp_q[$];
  logic [1:0]  grant_log[$];
  int checks = 0;
  int failures = 0;
  logic [7:0] last_b0, last_b1;
  int last_cycles, last_gap;
  logic last_nack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req_v);
    end
  endtask

  // ---------------- bus monitor, slave model, compare process ----------------
  initial begin : monitor
    int rise_cnt, cyc, gap, exp_rises, exp_quarters;
    logic [7:0] b0, b1;
    logic prev_scl, prev_oe, prev_done, saw_start, saw_stop, in_txn, ack_a, ack_d, exp_nack;
    logic [18:0] cur;
    rise_cnt = 0; cyc = 0; gap = 0; b0 = '0; b1 = '0;
    prev_scl = 1'b1; prev_oe = 1'b0; prev_done = 1'b0;
    saw_start = 1'b0; saw_stop = 1'b0; in_txn = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rise_cnt = 0; cyc = 0; in_txn = 1'b0; saw_start = 1'b0; saw_stop = 1'b0;
        prev_scl = 1'b1; prev_oe = 1'b0; prev_done = 1'b0;
        bus.sda_i = 1'b1;
      end else begin
        gap++;
        if (in_txn) cyc++;
        // new owner appears on entry to START
        if (!in_txn && bus.grant != '0) begin
          in_txn = 1'b1; cyc = 0; last_gap = gap; rise_cnt = 0;
          b0 = '0; b1 = '0; saw_start = 1'b0; saw_stop = 1'b0;
          grant_log.push_back(bus.grant);
          if (exp_q.size() == 0) check("grant_unexpected", 32'(bus.grant), 32'(0));
          else begin
            cur = exp_q[0];
            check("grant_owner", 32'(bus.grant), 32'(cur[18:17]));
          end
        end
        // bit capture on SCL rise: 1..8 address byte, 9 ack, 10..17 data, 18 ack, then STOP rise
        if (in_txn && !prev_scl && bus.scl) begin
          rise_cnt++;
          if (rise_cnt <= 8) b0 = {b0[6:0], ~bus.sda_oe};
          else if (rise_cnt >= 10 && rise_cnt <= 17) b1 = {b1[6:0], ~bus.sda_oe};
        end
        // SDA may only move under high SCL for START (pull) and STOP (release)
        if (bus.scl && prev_scl && (bus.sda_oe != prev_oe)) begin
          if (bus.sda_oe && in_txn && !saw_start && rise_cnt == 0) saw_start = 1'b1;
          else if (!bus.sda_oe && in_txn && saw_start && !saw_stop) saw_stop = 1'b1;
          else check("sda_edge_while_scl_high", 32'(bus.sda_oe), 32'(prev_oe));
        end
        // slave: drive ACK/NACK during the low phase ahead of the 9th and 18th rises
        ack_a = 1'b1; ack_d = 1'b1;
        if (exp_q.size() > 0) begin
          cur = exp_q[0];
          ack_a = cur[1]; ack_d = cur[0];
        end
        if (in_txn && !bus.scl) begin
          if (rise_cnt == 8) bus.sda_i = ack_a ? 1'b0 : 1'b1;
          else if (rise_cnt == 17) bus.sda_i = ack_d ? 1'b0 : 1'b1;
          else bus.sda_i = 1'b1;
        end
        if (bus.done) begin
          if (prev_done) check("done_single_cycle", 32'(bus.done), 32'(0));
          if (exp_q.size() == 0) check("done_unexpected", 32'(exp_q.size()), 32'(1));
          else begin
            cur = exp_q.pop_front();
            exp_quarters = cur[1] ? 80 : 44;
            exp_rises    = cur[1] ? 19 : 10;
            exp_nack     = !(cur[1] && cur[0]);
            check("byte_addr", 32'(b0), 32'({cur[16:10], 1'b0}));
            if (cur[1]) check("byte_data", 32'(b1), 32'(cur[9:2]));
            check("scl_rises", 32'(rise_cnt), 32'(exp_rises));
            check("nack", 32'(bus.nack), 32'(exp_nack));
            check("txn_cycles", 32'(cyc), 32'(exp_quarters * CLK_DIV));
            check("start_seen", 32'(saw_start), 32'(1));
            check("stop_seen", 32'(saw_stop), 32'(1));
            check("done_in_txn", 32'(in_txn), 32'(1));
            check("done_grant", 32'(bus.grant), 32'(0));
            check("done_busy", 32'(bus.busy), 32'(0));
          end
          last_b0 = b0; last_b1 = b1; last_cycles = cyc; last_nack = bus.nack;
          in_txn = 1'b0; gap = 0; rise_cnt = 0;
        end
        // per-cycle invariants
        check("grant_onehot0", 32'($onehot0(bus.grant)), 32'(1));
        check("grant_implies_busy", 32'((bus.grant == '0) || bus.busy), 32'(1));
        if (!bus.busy) check("idle_lines", 32'({bus.scl, bus.sda_oe}), 32'(2'b10));
        prev_scl = bus.scl; prev_oe = bus.sda_oe; prev_done = bus.done;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_grant(input string name);
    int n;
    n = 0;
    while (bus.grant == '0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.grant == '0) check({name, "_grant_timeout"}, 32'(bus.grant), 32'(1));
    #1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 1000);
    if (!bus.done) check({name, "_done_timeout"}, 32'(bus.done), 32'(1));
    #1;
  endtask

  task automatic set_req(input int idx, input logic [6:0] a, input logic [7:0] d);
    bus.req_addr[idx*7 +: 7] = a;
    bus.req_data[idx*8 +: 8] = d;
  endtask

  task automatic push_exp(input int idx, input logic [6:0] a, input logic [7:0] d,
                          input logic ack_a, input logic ack_d);
    logic [1:0] g;
    g = '0;
    g[idx] = 1'b1;
    exp_q.push_back({g, a, d, ack_a, ack_d});
  endtask

  task automatic run_one(input string name, input int idx, input logic [6:0] a, input logic [7:0] d,
                         input logic ack_a, input logic ack_d);
    push_exp(idx, a, d, ack_a, ack_d);
    @(negedge clk);
    set_req(idx, a, d);
    bus.req[idx] = 1'b1;
    wait_grant(name);
    bus.req[idx] = 1'b0;
    wait_done(name);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // watchdog
  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    repeat (3) @(negedge clk);
    check("rst_grant", 32'(bus.grant), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_nack", 32'(bus.nack), 32'(0));
    check("rst_scl", 32'(bus.scl), 32'(1));
    check("rst_sda_oe", 32'(bus.sda_oe), 32'(0));
    check("rst_state", 32'(dbg_state), 32'(i2c_pkg::S_IDLE));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: plain write, both slots acknowledged
    run_one("t1", 0, 7'h2A, 8'hA5, 1'b1, 1'b1);
    check("t1_addr_byte", 32'(last_b0), 32'(8'h54));
    check("t1_data_byte", 32'(last_b1), 32'(8'hA5));
    check("t1_cycles", 32'(last_cycles), 32'(320));
    check("t1_nack", 32'(last_nack), 32'(0));

    // 2: address NACK, data skipped
    run_one("t2", 0, 7'h2A, 8'hA5, 1'b0, 1'b1);
    check("t2_cycles", 32'(last_cycles), 32'(176));
    check("t2_nack", 32'(last_nack), 32'(1));

    // 3: data NACK only
    run_one("t3", 0, 7'h2A, 8'hA5, 1'b1, 1'b0);
    check("t3_cycles", 32'(last_cycles), 32'(320));
    check("t3_nack", 32'(last_nack), 32'(1));
    repeat (5) @(negedge clk);
    check("t3_nack_held", 32'(bus.nack), 32'(1));

    // boundary addresses/data on each requester; nack clears in ARB
    push_exp(1, 7'h7F, 8'h00, 1'b1, 1'b1);
    @(negedge clk);
    set_req(1, 7'h7F, 8'h00);
    bus.req[1] = 1'b1;
    wait_grant("tb1");
    check("tb1_nack_cleared", 32'(bus.nack), 32'(0));
    bus.req[1] = 1'b0;
    wait_done("tb1");
    check("tb1_addr_byte", 32'(last_b0), 32'(8'hFE));
    check("tb1_data_byte", 32'(last_b1), 32'(8'h00));
    run_one("tb2", 0, 7'h00, 8'hFF, 1'b1, 1'b1);
    check("tb2_addr_byte", 32'(last_b0), 32'(8'h00));
    check("tb2_data_byte", 32'(last_b1), 32'(8'hFF));

    // 4: simultaneous requests right after reset, held for three rounds
    grant_log.delete();
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 7'h11, 8'h3C);
    set_req(1, 7'h55, 8'hC3);
    bus.req = 2'b11;
    push_exp(0, 7'h11, 8'h3C, 1'b1, 1'b1);
    push_exp(1, 7'h55, 8'hC3, 1'b1, 1'b1);
    push_exp(0, 7'h11, 8'h3C, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_done("t4a");
    wait_grant("t4b");
    check("t4_gap", 32'(last_gap), 32'(2));
    wait_done("t4b");
    wait_done("t4c");
    bus.req = 2'b00;
    repeat (10) @(negedge clk);
    check("t4_count", 32'(grant_log.size()), 32'(3));
    if (grant_log.size() == 3) begin
      check("t4_g0", 32'(grant_log[0]), 32'(2'b01));
      check("t4_g1", 32'(grant_log[1]), 32'(2'b10));
      check("t4_g2", 32'(grant_log[2]), 32'(2'b01));
    end
    check("t4_idle_after", 32'(bus.busy), 32'(0));

    // 5: async reset during address bit 3, request held through reset
    pulse_reset();
    push_exp(0, 7'h2A, 8'hA5, 1'b1, 1'b1);
    @(negedge clk);
    set_req(0, 7'h2A, 8'hA5);
    bus.req[0] = 1'b1;
    wait_grant("t5");
    repeat (69) @(negedge clk);
    check("t5_busy_before", 32'(bus.busy), 32'(1));
    #1 rst = 1'b1;
    #1;
    check("t5_scl", 32'(bus.scl), 32'(1));
    check("t5_sda_oe", 32'(bus.sda_oe), 32'(0));
    check("t5_grant", 32'(bus.grant), 32'(0));
    check("t5_busy", 32'(bus.busy), 32'(0));
    check("t5_done", 32'(bus.done), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_grant("t5r");
    bus.req[0] = 1'b0;
    wait_done("t5r");
    check("t5_addr_byte", 32'(last_b0), 32'(8'h54));
    check("t5_cycles", 32'(last_cycles), 32'(320));

    repeat (5) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
